// File: rtl/stream_bit_unpacker.sv
// Regroups a stream of variable-length bit words (LSB first) into fixed SYM_W-bit symbols.
// At the end of a packet the remaining bits are flushed out as a final, possibly short, symbol.
module stream_bit_unpacker #(
  parameter int SYM_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      s_tdata,
  input  logic [4:0]       s_tkeep,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [SYM_W-1:0] m_tdata,
  output logic [4:0]       m_tkeep,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready
);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [5:0] SYM_CNT = 6'(SYM_W);

  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [0:0]  state_q, state_d;
  logic        ready_en_q;

  logic [4:0]  keep_sat;
  logic [15:0] keep_mask;
  logic [15:0] data_masked;
  logic [4:0]  pop_cnt;
  logic [5:0]  base_cnt;
  logic        in_fire;
  logic        out_fire;

  assign keep_sat    = (s_tkeep > 5'd16) ? 5'd16 : s_tkeep;
  assign keep_mask   = (keep_sat == 5'd16) ? 16'hFFFF : ((16'd1 << keep_sat) - 16'd1);
  assign data_masked = s_tdata & keep_mask;

  // Every output is decoded from registers only, so nothing ripples from m_tready back to s_tready.
  assign s_tready = ready_en_q && (state_q == FILL) && (cnt_q <= 6'd16);
  assign m_tvalid = (cnt_q >= SYM_CNT) || (state_q == FLUSH);
  assign pop_cnt  = (cnt_q < SYM_CNT) ? cnt_q[4:0] : SYM_CNT[4:0];
  assign m_tkeep  = pop_cnt;
  assign m_tdata  = acc_q[SYM_W-1:0];
  assign m_tlast  = (state_q == FLUSH) && (cnt_q <= SYM_CNT);

  assign in_fire  = s_tvalid && s_tready;
  assign out_fire = m_tvalid && m_tready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    base_cnt = cnt_q;

    if (out_fire) begin
      acc_d    = acc_q >> SYM_W;
      base_cnt = cnt_q - {1'b0, pop_cnt};
      cnt_d    = base_cnt;
    end

    // Appending after the pop keeps the new bits contiguous with whatever is left.
    if (in_fire) begin
      acc_d = acc_d | ({16'd0, data_masked} << base_cnt);
      cnt_d = base_cnt + {1'b0, keep_sat};
      if (s_tlast) state_d = FLUSH;
    end

    if (out_fire && m_tlast) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = FILL;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers update with non-blocking assignments so all of them see pre-edge values.
    if (!reset_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      state_q    <= FILL;
      ready_en_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_bit_unpacker.sv
// Bench for stream_bit_unpacker (SYM_W = 4): a bit-queue model checked every cycle,
// plus directed packets whose emitted symbols are pinned to hand-computed values.
module tb_stream_bit_unpacker;

  localparam int SYM_W = 4;

  logic             clk;
  logic             reset_n;
  logic [15:0]      s_tdata;
  logic [4:0]       s_tkeep;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic [SYM_W-1:0] m_tdata;
  logic [4:0]       m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;

  stream_bit_unpacker #(.SYM_W(SYM_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] data;
    logic [4:0] keep;
    logic       last;
  } sym_t;

  sym_t log_q[$];

  // Model state: pending bits in arrival order, whether the packet end was seen,
  // and whether the block is still in its first cycle out of reset.
  bit mq[$];
  bit m_flush     = 1'b0;
  bit m_rst_block = 1'b1;
  bit check_en    = 1'b0;

  always @(negedge clk) begin
    int         n;
    int         ks;
    logic [3:0] ed;
    logic [4:0] ek;
    logic       ev;
    logic       el;
    logic       er;
    n  = mq.size();
    ek = (n < SYM_W) ? 5'(n) : 5'(SYM_W);
    ed = '0;
    for (int i = 0; i < int'(ek); i++) ed[i] = mq[i];
    ev = (n >= SYM_W) || m_flush;
    el = m_flush && (n <= SYM_W);
    er = !m_rst_block && !m_flush && (n <= 16);

    if (check_en) begin
      check("s_tready", {31'd0, s_tready}, {31'd0, er});
      check("m_tvalid", {31'd0, m_tvalid}, {31'd0, ev});
      if (ev) begin
        check("m_tdata", {28'd0, m_tdata}, {28'd0, ed});
        check("m_tkeep", {27'd0, m_tkeep}, {27'd0, ek});
        check("m_tlast", {31'd0, m_tlast}, {31'd0, el});
      end
    end

    if (reset_n && m_tvalid && m_tready) log_q.push_back({m_tdata, m_tkeep, m_tlast});

    // Advance the model by what the coming rising edge will do.
    if (!reset_n) begin
      mq.delete();
      m_flush     = 1'b0;
      m_rst_block = 1'b1;
      check_en    = 1'b1;
    end else begin
      m_rst_block = 1'b0;
      if (ev && m_tready) begin
        if (el) begin
          mq.delete();
          m_flush = 1'b0;
        end else begin
          for (int i = 0; i < int'(ek); i++) void'(mq.pop_front());
        end
      end
      if (s_tvalid && er) begin
        ks = (s_tkeep > 5'd16) ? 16 : int'(s_tkeep);
        for (int i = 0; i < ks; i++) mq.push_back(s_tdata[i]);
        if (s_tlast) m_flush = 1'b1;
      end
    end
  end

  task automatic send_word(input logic [15:0] d, input logic [4:0] k, input logic l);
    bit hs;
    hs       = 1'b0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
    end
    if (!hs) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_word: word 0x%0h never accepted, expected acceptance within 200 cycles", d);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic expect_count(input string name, input int n);
    for (int t = 0; t < 300 && log_q.size() < n; t++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check(name, log_q.size(), n);
  endtask

  task automatic check_sym(input string name, input int idx,
                           input logic [3:0] d, input logic [4:0] k, input logic l);
    sym_t got;
    sym_t exp;
    exp = {d, k, l};
    got = (idx < log_q.size()) ? log_q[idx] : '1;
    check(name, {22'd0, got}, {22'd0, exp});
  endtask

  initial begin
    reset_n  = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset s_tready", {31'd0, s_tready}, 32'd0);
    check("reset m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("reset m_tdata",  {28'd0, m_tdata},  32'd0);
    check("reset m_tkeep",  {27'd0, m_tkeep},  32'd0);
    check("reset m_tlast",  {31'd0, m_tlast},  32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready after reset", {31'd0, s_tready}, 32'd1);

    // Full word, no packet end.
    log_q.delete();
    send_word(16'hABCD, 5'd16, 1'b0);
    expect_count("abcd count", 4);
    check_sym("abcd s0", 0, 4'hD, 5'd4, 1'b0);
    check_sym("abcd s1", 1, 4'hC, 5'd4, 1'b0);
    check_sym("abcd s2", 2, 4'hB, 5'd4, 1'b0);
    check_sym("abcd s3", 3, 4'hA, 5'd4, 1'b0);

    // Short last word leaves a 2-bit tail.
    log_q.delete();
    send_word(16'h00F5, 5'd6, 1'b1);
    expect_count("f5 count", 2);
    check_sym("f5 s0", 0, 4'h5, 5'd4, 1'b0);
    check_sym("f5 s1", 1, 4'h3, 5'd2, 1'b1);

    // Two words stitched across a symbol boundary.
    log_q.delete();
    send_word(16'h0005, 5'd3, 1'b0);
    send_word(16'h001A, 5'd5, 1'b1);
    expect_count("stitch count", 2);
    check_sym("stitch s0", 0, 4'h5, 5'd4, 1'b0);
    check_sym("stitch s1", 1, 4'hD, 5'd4, 1'b1);

    // Empty last word on an empty accumulator.
    log_q.delete();
    send_word(16'hFFFF, 5'd0, 1'b1);
    expect_count("empty count", 1);
    check_sym("empty s0", 0, 4'h0, 5'd0, 1'b1);

    // Keep above 16 saturates; keep below 16 masks the upper bits.
    log_q.delete();
    send_word(16'hFFFF, 5'd20, 1'b1);
    expect_count("sat count", 4);
    check_sym("sat s0", 0, 4'hF, 5'd4, 1'b0);
    check_sym("sat s3", 3, 4'hF, 5'd4, 1'b1);
    log_q.delete();
    send_word(16'hFFFF, 5'd5, 1'b1);
    expect_count("mask count", 2);
    check_sym("mask s0", 0, 4'hF, 5'd4, 1'b0);
    check_sym("mask s1", 1, 4'h1, 5'd1, 1'b1);

    // Downstream stall while full words keep arriving.
    log_q.delete();
    m_tready = 1'b0;
    fork
      begin
        for (int w = 0; w < 3; w++) send_word(16'hABCD, 5'd16, 1'b0);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        check("stall s_tready", {31'd0, s_tready}, 32'd0);
        check("stall m_tdata",  {28'd0, m_tdata},  32'hD);
        check("stall m_tkeep",  {27'd0, m_tkeep},  32'd4);
        m_tready = 1'b1;
      end
    join
    expect_count("stall count", 12);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] word;
      word = 16'hABCD;
      check_sym($sformatf("stall s%0d", i), i, word[4*(i%4) +: 4], 5'd4, 1'b0);
    end

    // Reset in the middle of a flush, then a clean packet.
    log_q.delete();
    m_tready = 1'b0;
    send_word(16'hABCD, 5'd16, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst s_tready", {31'd0, s_tready}, 32'd0);
    check("midrst m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("midrst m_tdata",  {28'd0, m_tdata},  32'd0);
    check("midrst m_tkeep",  {27'd0, m_tkeep},  32'd0);
    check("midrst m_tlast",  {31'd0, m_tlast},  32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst ready", {31'd0, s_tready}, 32'd1);
    m_tready = 1'b1;
    send_word(16'h00F5, 5'd6, 1'b1);
    expect_count("post-reset count", 2);
    check_sym("post-reset s0", 0, 4'h5, 5'd4, 1'b0);
    check_sym("post-reset s1", 1, 4'h3, 5'd2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
